// File: rtl/mp_add_sequencer.sv
// Multi-precision add controller: streams WORDS 16-bit limbs, LS limb first,
// through an external 16-bit ripple adder and assembles the wide sum, carry and overflow.
module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  cin,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic [3:0]            add_cout,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IW-1:0]   idx_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    work_r;
    logic [W-1:0]    work_s;
    logic [W-1:0]    result_r;
    logic            carry_r;
    logic            cout_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;
    logic            last_s;
    logic            ovf_s;
    logic [15:0]     limb_a_s;
    logic [15:0]     limb_b_s;
    logic [15:0]     add_a_s;
    logic [15:0]     add_b_s;
    logic            add_cin_s;
    logic            unused_cout_s;

    // Only the top group carry chains between limbs.
    assign unused_cout_s = ^add_cout[2:0];

    assign last_s = (idx_r == IW'(WORDS - 1));
    assign ovf_s  = (a_r[W-1] == b_r[W-1]) && (add_sum[15] != a_r[W-1]);

    // Current limb selection and the working value with this cycle's limb merged in.
    always_comb begin
        limb_a_s = a_r[{idx_r, 4'b0000} +: 16];
        limb_b_s = b_r[{idx_r, 4'b0000} +: 16];
        work_s   = work_r;
        work_s[{idx_r, 4'b0000} +: 16] = add_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Adder drive: limbs only while running, otherwise held at zero.
    always_comb begin
        add_a_s   = 16'h0000;
        add_b_s   = 16'h0000;
        add_cin_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                add_a_s   = limb_a_s;
                add_b_s   = limb_b_s;
                add_cin_s = carry_r;
            end
            default: begin
                add_a_s   = 16'h0000;
                add_b_s   = 16'h0000;
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Operand capture, limb accumulation, carry chaining and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            work_r   <= '0;
            carry_r  <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= op_a;
                        b_r     <= op_b;
                        carry_r <= cin;
                        idx_r   <= '0;
                        work_r  <= '0;
                    end
                end
                ST_RUN: begin
                    work_r  <= work_s;
                    carry_r <= add_cout[3];
                    idx_r   <= idx_r + IW'(1);
                    if (last_s) begin
                        result_r <= work_s;
                        cout_r   <= add_cout[3];
                        ovf_r    <= ovf_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a   = add_a_s;
    assign add_b   = add_b_s;
    assign add_cin = add_cin_s;
    assign result  = result_r;
    assign cout    = cout_r;
    assign ovf     = ovf_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
